id_checker_param: RTL and testbench

Parametrised successor to the team's fixed-format ID check-digit block. It consumes one ID per frame as a serial stream on in_valid/in_id:
- one two-digit prefix code beat, then NUM_DIGITS digit beats, the last being the check digit.
- It accumulates a weighted checksum modulo MOD and reports legal/illegal one cycle after the frame ends.

It adds range checking, gap-abort, back-to-back frame support and a saturating legal-ID counter. It sits on the ID-verification datapath, fed by the input deserialiser.

---
 rtl/id_checker_param.sv | 139 +++++++++++++
 tb/tb_id_checker_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_checker_param.sv
// id_checker_param: serial ID check-digit verifier.
// Each frame is one prefix beat followed by NUM_DIGITS digit beats. A weighted
// checksum mod MOD is accumulated, and a registered result pulse is produced
// one cycle after the frame ends or after a gap abort.
// Ports: clk/rst (sync, active-high); in_valid/in_id beat input;
//   out_valid/out_legal_id/out_err result pulse; busy (frame in progress);
//   legal_cnt (saturating count of legal frames).
module id_checker_param #(
  parameter int unsigned NUM_DIGITS = 9,
  parameter int unsigned MOD        = 10,
  parameter int unsigned PREFIX_MIN = 10,
  parameter int unsigned PREFIX_MAX = 35,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       in_id,
  output logic             out_valid,
  output logic             out_legal_id,
  output logic             out_err,
  output logic             busy,
  output logic [CNT_W-1:0] legal_cnt
);

  localparam int unsigned RW    = $clog2(MOD);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);
  // An out-of-range digit (up to 63) is still accumulated, so the
  // intermediate is sized for 63 * weight rather than 9 * weight.
  localparam int unsigned SUM_W = $clog2(63 * NUM_DIGITS + MOD) + 1;

  typedef enum logic {IDLE, DIGITS} state_e;

  state_e             state_q, state_d;
  logic [RW-1:0]      r_q, r_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;
  logic               out_legal_q, out_legal_d;
  logic               out_err_q, out_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SUM_W-1:0]   weight;
  logic [SUM_W-1:0]   digit_acc;
  logic [RW-1:0]      digit_r;
  logic [5:0]         pfx_t, pfx_u;
  logic [SUM_W-1:0]   pfx_acc;
  logic [RW-1:0]      pfx_r;
  logic               pfx_bad;
  logic               last_beat;

  always_comb begin
    last_beat = (idx_q == IDX_W'(NUM_DIGITS));
    weight    = last_beat ? SUM_W'(1) : (SUM_W'(NUM_DIGITS) - SUM_W'(idx_q));
    digit_acc = SUM_W'(r_q) + weight * SUM_W'(in_id);
    digit_r   = RW'(digit_acc % SUM_W'(MOD));

    pfx_t   = in_id / 6'd10;
    pfx_u   = in_id % 6'd10;
    pfx_acc = SUM_W'(pfx_t) + SUM_W'(pfx_u) * SUM_W'(NUM_DIGITS);
    pfx_r   = RW'(pfx_acc % SUM_W'(MOD));
    pfx_bad = (in_id < 6'(PREFIX_MIN)) || (in_id > 6'(PREFIX_MAX));

    state_d     = state_q;
    r_d         = r_q;
    idx_d       = idx_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    out_legal_d = 1'b0;
    out_err_d   = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = pfx_r;
          err_d   = pfx_bad;
          idx_d   = IDX_W'(1);
          state_d = DIGITS;
        end
      end
      DIGITS: begin
        if (in_valid) begin
          r_d   = digit_r;
          err_d = err_q | (in_id > 6'd9);
          if (last_beat) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_legal_d = (digit_r == '0) && !err_d;
            out_err_d   = err_d;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          state_d     = IDLE;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter updates alongside the registered pulse so it is current
    // in the same cycle out_valid/out_legal_id are seen.
    if (out_valid_d && out_legal_d && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_legal_q <= 1'b0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_legal_q <= out_legal_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_legal_id = out_legal_q;
  assign out_err      = out_err_q;
  assign busy         = (state_q == DIGITS);
  assign legal_cnt    = cnt_q;

endmodule

// File: tb/tb_id_checker_param.sv
module tb_id_checker_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_v, b_v;
  logic [5:0] a_id, b_id;
  logic       a_ov, a_legal, a_err, a_busy;
  logic       b_ov, b_legal, b_err, b_busy;
  logic [7:0] a_cnt, b_cnt;

  id_checker_param u_a (
    .clk(clk), .rst(rst), .in_valid(a_v), .in_id(a_id),
    .out_valid(a_ov), .out_legal_id(a_legal), .out_err(a_err),
    .busy(a_busy), .legal_cnt(a_cnt)
  );

  id_checker_param #(.NUM_DIGITS(5), .MOD(11), .PREFIX_MIN(10), .PREFIX_MAX(35), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_v), .in_id(b_id),
    .out_valid(b_ov), .out_legal_id(b_legal), .out_err(b_err),
    .busy(b_busy), .legal_cnt(b_cnt)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        legal;
    logic        err;
    int unsigned at;
  } exp_t;

  typedef struct {
    logic [5:0]      pfx;
    logic [8:0][5:0] dig;    // dig[8] is the first digit beat
    int unsigned     ndig;   // digit beats sent; < 9 means a gap follows
    logic            exp_legal;
    logic            exp_err;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (a_ov) begin
        exp_t e;
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL a_unexpected_valid: got out_valid=1 expected no pending frame");
        end else begin
          e = qa.pop_front();
          check("a_latency", cyc, e.at);
          check("a_legal", a_legal, e.legal);
          check("a_err", a_err, e.err);
          if (e.legal && cnt_a != 255) cnt_a++;
        end
      end else begin
        check("a_idle_zero", {a_legal, a_err}, 0);
      end
      check("a_cnt", a_cnt, cnt_a);

      if (b_ov) begin
        exp_t e;
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected_valid: got out_valid=1 expected no pending frame");
        end else begin
          e = qb.pop_front();
          check("b_latency", cyc, e.at);
          check("b_legal", b_legal, e.legal);
          check("b_err", b_err, e.err);
          if (e.legal && cnt_b != 255) cnt_b++;
        end
      end else begin
        check("b_idle_zero", {b_legal, b_err}, 0);
      end
      check("b_cnt", b_cnt, cnt_b);
    end
  end

  task automatic beat_a(input logic v, input logic [5:0] id, input logic exp_busy);
    @(posedge clk); #1;
    a_v  = v;
    a_id = id;
    check("a_busy", a_busy, exp_busy);
  endtask

  task automatic beat_b(input logic v, input logic [5:0] id, input logic exp_busy);
    @(posedge clk); #1;
    b_v  = v;
    b_id = id;
    check("b_busy", b_busy, exp_busy);
  endtask

  task automatic send_a(input vec_t v);
    beat_a(1'b1, v.pfx, 1'b0);
    for (int unsigned i = 0; i < v.ndig; i++) beat_a(1'b1, v.dig[8-i], 1'b1);
    if (v.ndig < 9) beat_a(1'b0, 6'd0, 1'b1);
    qa.push_back('{v.exp_legal, v.exp_err, cyc + 1});
  endtask

  task automatic drain(input string name);
    for (int unsigned i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, qa.size() + qb.size());
    end
  endtask

  vec_t tbl[14];

  initial begin
    int unsigned p, s, nb, gap_at, c;
    logic        e, gap, lg;
    logic [5:0]  d[1:5];

    tbl[0]  = '{6'd10, {6'd1,6'd2,6'd3,6'd4,6'd5,6'd6,6'd7,6'd8,6'd9}, 9, 1'b1, 1'b0};
    tbl[1]  = '{6'd10, {6'd1,6'd2,6'd3,6'd4,6'd5,6'd6,6'd7,6'd8,6'd8}, 9, 1'b0, 1'b0};
    tbl[2]  = '{6'd10, {6'd1,6'd2,6'd3,6'd4,6'd5,6'd6,6'd7,6'd8,6'd9}, 9, 1'b1, 1'b0};
    tbl[3]  = '{6'd11, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0}, 9, 1'b1, 1'b0};
    tbl[4]  = '{6'd7,  {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd7}, 9, 1'b0, 1'b1};
    tbl[5]  = '{6'd10, {6'd1,6'd12,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0}, 9, 1'b0, 1'b1};
    tbl[6]  = '{6'd10, {6'd1,6'd2,6'd3,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0}, 3, 1'b0, 1'b1};
    tbl[7]  = '{6'd10, {6'd1,6'd2,6'd3,6'd4,6'd5,6'd6,6'd7,6'd8,6'd9}, 9, 1'b1, 1'b0};
    tbl[8]  = '{6'd36, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd4}, 9, 1'b0, 1'b1};
    tbl[9]  = '{6'd35, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd2}, 9, 1'b1, 1'b0};
    tbl[10] = '{6'd10, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0}, 0, 1'b0, 1'b1};
    tbl[11] = '{6'd63, {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd7}, 9, 1'b0, 1'b1};
    tbl[12] = '{6'd9,  {6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd0,6'd9}, 9, 1'b0, 1'b1};
    tbl[13] = '{6'd10, {6'd9,6'd9,6'd9,6'd9,6'd9,6'd9,6'd9,6'd9,6'd5}, 9, 1'b1, 1'b0};

    rst = 1'b1; a_v = 1'b0; a_id = '0; b_v = 1'b0; b_id = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_outputs", {a_ov, a_legal, a_err, a_busy, a_cnt}, 0);
    check("rst_b_outputs", {b_ov, b_legal, b_err, b_busy, b_cnt}, 0);
    rst = 1'b0;

    // Contiguous frames: back-to-back, gap followed by a new prefix, range errors
    for (int unsigned i = 0; i < 14; i++) send_a(tbl[i]);
    beat_a(1'b0, 6'd0, 1'b0);
    drain("table");

    // Reset mid-frame discards the frame without a result pulse
    beat_a(1'b1, 6'd10, 1'b0);
    beat_a(1'b1, 6'd1, 1'b1);
    beat_a(1'b1, 6'd2, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; a_v = 1'b0;
    cnt_a = 0; cnt_b = 0;
    @(posedge clk); #1;
    check("midrst_a_outputs", {a_ov, a_legal, a_err, a_busy, a_cnt}, 0);
    rst = 1'b0;
    repeat (4) beat_a(1'b0, 6'd0, 1'b0);
    send_a(tbl[0]);
    beat_a(1'b0, 6'd0, 1'b0);
    drain("after_rst");

    // NUM_DIGITS=5, MOD=11 random frames against a full-sum reference
    for (int unsigned f = 0; f < 1000; f++) begin
      p = ($urandom % 10 == 0) ? $urandom_range(0, 63) : $urandom_range(10, 35);
      e = (p < 10) || (p > 35);
      s = (p / 10) + (p % 10) * 5;
      for (int unsigned k = 1; k <= 4; k++) begin
        d[k] = ($urandom % 25 == 0) ? 6'($urandom_range(10, 63)) : 6'($urandom_range(0, 9));
        e = e | (d[k] > 6'd9);
        s = s + d[k] * (5 - k);
      end
      c = (11 - (s % 11)) % 11;
      if (($urandom % 2 == 0) || c > 9) c = $urandom_range(0, 9);
      d[5] = 6'(c);
      s = s + c;
      lg = !e && (s % 11 == 0);
      gap = ($urandom % 40 == 0);
      gap_at = $urandom_range(0, 4);
      nb = gap ? gap_at : 5;
      beat_b(1'b1, 6'(p), 1'b0);
      for (int unsigned k = 1; k <= nb; k++) beat_b(1'b1, d[k], 1'b1);
      if (gap) begin
        beat_b(1'b0, 6'd0, 1'b1);
        qb.push_back('{1'b0, 1'b1, cyc + 1});
      end else begin
        qb.push_back('{lg, e, cyc + 1});
      end
    end
    beat_b(1'b0, 6'd0, 1'b0);
    drain("random");
    check("b_cnt_saturated", b_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
